// File: rtl/pc_sequencer.sv
// Fetch-stage PC sequencer: owns the fetch address, handshakes with
// instruction memory, and hands accepted instructions to IF/ID.
// Redirects arriving while a fetch is outstanding are parked until the ack
// so the address never moves under an in-flight request.
module pc_sequencer #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] PC_STEP      = 32'd1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  input  logic        imem_ack,
  output logic        imem_req,
  output logic [31:0] pc,
  output logic [31:0] npc,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic        flush
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t      state;
  logic        pend_v;
  logic [31:0] pend_pc;

  logic        redir;
  logic [31:0] redir_tgt;

  // Sequential address wraps naturally in 32 bits
  assign npc = pc + PC_STEP;

  // Branch wins over jump when both fire in the same cycle
  always_comb begin
    redir     = branch_taken | jump;
    redir_tgt = branch_taken ? branch_target : jump_target;
  end

  // Fetch FSM; imem_req is registered alongside the state so it is 1 exactly in FETCH
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      pc       <= RESET_VECTOR;
      pend_v   <= 1'b0;
      pend_pc  <= 32'h0;
      if_valid <= 1'b0;
      if_pc    <= 32'h0;
      flush    <= 1'b0;
      imem_req <= 1'b0;
    end else begin
      if_valid <= 1'b0;
      flush    <= 1'b0;
      case (state)
        IDLE: begin
          state    <= FETCH;
          imem_req <= 1'b1;
        end
        FETCH: begin
          if (!imem_ack) begin
            // Request outstanding: pc frozen, remember the newest redirect
            if (redir) begin
              pend_v  <= 1'b1;
              pend_pc <= redir_tgt;
            end
          end else if (redir || pend_v) begin
            // Returned instruction is on the wrong path: drop it and redirect
            pc     <= redir ? redir_tgt : pend_pc;
            pend_v <= 1'b0;
            flush  <= 1'b1;
            if (stall) begin
              state    <= HOLD;
              imem_req <= 1'b0;
            end
          end else if (stall) begin
            // Downstream cannot take it; refetch the same pc after the stall
            state    <= HOLD;
            imem_req <= 1'b0;
          end else begin
            if_valid <= 1'b1;
            if_pc    <= pc;
            pc       <= npc;
          end
        end
        HOLD: begin
          if (redir) begin
            pc    <= redir_tgt;
            flush <= 1'b1;
          end
          if (!stall) begin
            state    <= FETCH;
            imem_req <= 1'b1;
          end
        end
        default: begin
          state    <= IDLE;
          imem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: inputs change 1ns after each rising edge,
// outputs are checked at that same point (i.e. after the edge has settled).
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        jump;
  logic [31:0] jump_target;
  logic        imem_ack;
  logic        imem_req;
  logic [31:0] pc;
  logic [31:0] npc;
  logic        if_valid;
  logic [31:0] if_pc;
  logic        flush;

  int checks = 0;
  int errors = 0;

  pc_sequencer dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .jump          (jump),
    .jump_target   (jump_target),
    .imem_ack      (imem_ack),
    .imem_req      (imem_req),
    .pc            (pc),
    .npc           (npc),
    .if_valid      (if_valid),
    .if_pc         (if_pc),
    .flush         (flush)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; stall = 1'b0; branch_taken = 1'b0; branch_target = 32'h0;
    jump = 1'b0; jump_target = 32'h0; imem_ack = 1'b1;
    tick(); tick();
    checks++; if (pc !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h exp %h", pc, 32'h0); end
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b exp 0", imem_req); end
    checks++; if (if_valid !== 1'b0 || flush !== 1'b0) begin errors++; $display("FAIL reset_pulses: got if_valid=%b flush=%b exp 0/0", if_valid, flush); end
    checks++; if (if_pc !== 32'h0) begin errors++; $display("FAIL reset_if_pc: got %h exp 0", if_pc); end
  endtask

  // Ack tied high: request rises one cycle after release, then one instruction per cycle
  task automatic test_sequential();
    #2 rst_n = 1'b1;
    tick();
    checks++; if (imem_req !== 1'b1 || pc !== 32'h0 || if_valid !== 1'b0) begin errors++; $display("FAIL seq_start: got req=%b pc=%h v=%b exp 1/0/0", imem_req, pc, if_valid); end
    checks++; if (npc !== 32'h1) begin errors++; $display("FAIL seq_npc: got %h exp 1", npc); end
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (if_valid !== 1'b1 || if_pc !== i || pc !== i + 1) begin errors++; $display("FAIL seq_%0d: got v=%b if_pc=%h pc=%h exp 1/%h/%h", i, if_valid, if_pc, pc, i, i + 1); end
    end
    tick();
    checks++; if (pc !== 32'h5 || if_pc !== 32'h4) begin errors++; $display("FAIL seq_to5: got pc=%h if_pc=%h exp 5/4", pc, if_pc); end
  endtask

  // Ack low 3 cycles at pc=5 with a branch pulse parked, then ack applies it
  task automatic test_wait_redirect();
    imem_ack = 1'b0;
    branch_taken = 1'b1; branch_target = 32'h40;
    tick();
    branch_taken = 1'b0;
    checks++; if (pc !== 32'h5 || imem_req !== 1'b1) begin errors++; $display("FAIL wait_hold1: got pc=%h req=%b exp 5/1", pc, imem_req); end
    tick(); tick();
    checks++; if (pc !== 32'h5 || if_valid !== 1'b0 || flush !== 1'b0) begin errors++; $display("FAIL wait_hold3: got pc=%h v=%b fl=%b exp 5/0/0", pc, if_valid, flush); end
    imem_ack = 1'b1;
    tick();
    checks++; if (pc !== 32'h40 || flush !== 1'b1 || if_valid !== 1'b0) begin errors++; $display("FAIL wait_redir: got pc=%h fl=%b v=%b exp 40/1/0", pc, flush, if_valid); end
    tick();
    checks++; if (flush !== 1'b0 || if_valid !== 1'b1 || if_pc !== 32'h40 || pc !== 32'h41) begin errors++; $display("FAIL wait_after: got fl=%b v=%b if_pc=%h pc=%h exp 0/1/40/41", flush, if_valid, if_pc, pc); end
  endtask

  // Later pending redirect overwrites earlier; a current one overrides pending
  task automatic test_pending();
    imem_ack = 1'b0;
    branch_taken = 1'b1; branch_target = 32'h30;
    tick();
    branch_taken = 1'b0; jump = 1'b1; jump_target = 32'h50;
    tick();
    jump = 1'b0; imem_ack = 1'b1;
    tick();
    checks++; if (pc !== 32'h50 || flush !== 1'b1) begin errors++; $display("FAIL pend_overwrite: got pc=%h fl=%b exp 50/1", pc, flush); end
    imem_ack = 1'b0; jump = 1'b1; jump_target = 32'h60;
    tick();
    jump = 1'b0; imem_ack = 1'b1; branch_taken = 1'b1; branch_target = 32'h70;
    tick();
    branch_taken = 1'b0;
    checks++; if (pc !== 32'h70 || flush !== 1'b1) begin errors++; $display("FAIL pend_current: got pc=%h fl=%b exp 70/1", pc, flush); end
  endtask

  // Stall on the ack of pc=7: instruction dropped, HOLD 2 cycles, refetch 7
  task automatic test_stall();
    jump = 1'b1; jump_target = 32'h7;
    tick();
    jump = 1'b0;
    checks++; if (pc !== 32'h7) begin errors++; $display("FAIL stall_setup: got pc=%h exp 7", pc); end
    stall = 1'b1;
    tick();
    checks++; if (imem_req !== 1'b0 || pc !== 32'h7 || if_valid !== 1'b0) begin errors++; $display("FAIL stall_h1: got req=%b pc=%h v=%b exp 0/7/0", imem_req, pc, if_valid); end
    tick();
    checks++; if (imem_req !== 1'b0 || pc !== 32'h7 || if_valid !== 1'b0) begin errors++; $display("FAIL stall_h2: got req=%b pc=%h v=%b exp 0/7/0", imem_req, pc, if_valid); end
    stall = 1'b0;
    tick();
    checks++; if (imem_req !== 1'b1 || pc !== 32'h7 || if_valid !== 1'b0) begin errors++; $display("FAIL stall_resume: got req=%b pc=%h v=%b exp 1/7/0", imem_req, pc, if_valid); end
    tick();
    checks++; if (if_valid !== 1'b1 || if_pc !== 32'h7 || pc !== 32'h8) begin errors++; $display("FAIL stall_refetch: got v=%b if_pc=%h pc=%h exp 1/7/8", if_valid, if_pc, pc); end
  endtask

  // Branch and jump together in HOLD: branch wins, one flush pulse
  task automatic test_hold_priority();
    stall = 1'b1;
    tick();
    checks++; if (imem_req !== 1'b0 || pc !== 32'h8) begin errors++; $display("FAIL hp_enter: got req=%b pc=%h exp 0/8", imem_req, pc); end
    branch_taken = 1'b1; branch_target = 32'h10; jump = 1'b1; jump_target = 32'h20;
    tick();
    branch_taken = 1'b0; jump = 1'b0;
    checks++; if (pc !== 32'h10 || flush !== 1'b1 || imem_req !== 1'b0) begin errors++; $display("FAIL hp_redir: got pc=%h fl=%b req=%b exp 10/1/0", pc, flush, imem_req); end
    tick();
    checks++; if (flush !== 1'b0 || pc !== 32'h10) begin errors++; $display("FAIL hp_single: got fl=%b pc=%h exp 0/10", flush, pc); end
    stall = 1'b0;
    tick();
    checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL hp_exit: got req=%b exp 1", imem_req); end
  endtask

  // Address wraps from all-ones to zero
  task automatic test_wrap();
    jump = 1'b1; jump_target = 32'hFFFF_FFFF;
    tick();
    jump = 1'b0;
    checks++; if (pc !== 32'hFFFF_FFFF || npc !== 32'h0) begin errors++; $display("FAIL wrap_npc: got pc=%h npc=%h exp ffffffff/0", pc, npc); end
    tick();
    checks++; if (if_valid !== 1'b1 || if_pc !== 32'hFFFF_FFFF || pc !== 32'h0) begin errors++; $display("FAIL wrap: got v=%b if_pc=%h pc=%h exp 1/ffffffff/0", if_valid, if_pc, pc); end
  endtask

  // Reset mid-wait with a parked redirect: async clear, clean restart, no flush
  task automatic test_reset_mid();
    imem_ack = 1'b0;
    branch_taken = 1'b1; branch_target = 32'h55;
    tick();
    branch_taken = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checks++; if (pc !== 32'h0 || imem_req !== 1'b0 || flush !== 1'b0 || if_pc !== 32'h0) begin errors++; $display("FAIL rst_async: got pc=%h req=%b fl=%b if_pc=%h exp 0/0/0/0", pc, imem_req, flush, if_pc); end
    tick();
    #2 rst_n = 1'b1; imem_ack = 1'b1;
    tick();
    checks++; if (imem_req !== 1'b1 || pc !== 32'h0 || flush !== 1'b0) begin errors++; $display("FAIL rst_restart: got req=%b pc=%h fl=%b exp 1/0/0", imem_req, pc, flush); end
    tick();
    checks++; if (flush !== 1'b0 || if_valid !== 1'b1 || if_pc !== 32'h0 || pc !== 32'h1) begin errors++; $display("FAIL rst_nopend: got fl=%b v=%b if_pc=%h pc=%h exp 0/1/0/1", flush, if_valid, if_pc, pc); end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_wait_redirect();
    test_pending();
    test_stall();
    test_hold_priority();
    test_wrap();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
